// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Purpose : Instruction fetch front end. It issues word-aligned requests to the
//           instruction memory and hands fetched words to the IF/ID register
//           through a 1-entry output slot. A 1-entry skid buffer holds the word
//           that returns while IF/ID is stalled.
// Build option : define IF_PERF_COUNT_EN to add the FetchCount port and its
//           counter. FetchCount counts every Ack that is accepted and not
//           discarded.
// Ports  :
//   Clock           rising-edge clock
//   Reset           asynchronous, active-low reset
//   Stall           IF/ID hold request from the hazard unit
//   Redirect        taken branch/jump; flushes the slot and the skid buffer
//   RedirectTarget  new fetch address (low two bits ignored)
//   IMem_Req        memory request, held until IMem_Ack
//   IMem_Addr       word-aligned request address
//   IMem_Ack        memory response (may arrive in the same cycle as IMem_Req)
//   IMem_RData      instruction word, valid when IMem_Ack=1
//   Instruction_Out fetched word, or 0 when Valid_Out=0
//   PC_Out          fetch address + 4, or 0 when Valid_Out=0
//   Valid_Out       output slot holds a live instruction
//   FetchCount      accepted-fetch counter (IF_PERF_COUNT_EN only)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_RData,
  output logic [31:0] Instruction_Out,
  output logic [31:0] PC_Out,
  output logic        Valid_Out
`ifdef IF_PERF_COUNT_EN
  ,
  output logic [31:0] FetchCount
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_next_pc;
  logic [31:0] r_slot_instr;
  logic [31:0] r_slot_pc;
  logic        r_slot_vld;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        r_skid_vld;

  logic [31:0] w_tgt;
  logic [31:0] w_addr_p4;
  logic        w_consume;
  logic        w_capture;
  logic        w_cap_skid;

  assign w_tgt     = {RedirectTarget[31:2], 2'b00};
  assign w_addr_p4 = r_addr + 32'd4;  // wraps modulo 2^32
  assign w_consume = r_slot_vld && !Stall && !Redirect;
  assign w_capture = (r_state == S_REQ) && IMem_Ack && !Redirect;
  // The word goes to the skid buffer when the slot stays occupied after this
  // edge. That happens when the slot is not drained, or when it is refilled
  // from the skid buffer.
  assign w_cap_skid = w_capture && r_slot_vld && (!w_consume || r_skid_vld);

  assign IMem_Req        = (r_state != S_IDLE);
  assign IMem_Addr       = r_addr;
  assign Valid_Out       = r_slot_vld;
  assign Instruction_Out = r_slot_vld ? r_slot_instr : 32'd0;
  assign PC_Out          = r_slot_vld ? r_slot_pc    : 32'd0;

  // Output slot and skid buffer
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_slot_instr <= 32'd0;
      r_slot_pc    <= 32'd0;
      r_slot_vld   <= 1'b0;
      r_skid_instr <= 32'd0;
      r_skid_pc    <= 32'd0;
      r_skid_vld   <= 1'b0;
    end else if (Redirect) begin
      r_slot_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else begin
      if (w_consume && r_skid_vld) begin
        r_slot_instr <= r_skid_instr;
        r_slot_pc    <= r_skid_pc;
      end else if (w_capture && !w_cap_skid) begin
        r_slot_instr <= IMem_RData;
        r_slot_pc    <= w_addr_p4;
      end
      if (w_cap_skid) begin
        r_skid_instr <= IMem_RData;
        r_skid_pc    <= w_addr_p4;
      end
      r_slot_vld <= (r_slot_vld && !w_consume) || (w_consume && r_skid_vld) ||
                    (w_capture && !w_cap_skid);
      r_skid_vld <= (r_skid_vld && !w_consume) || w_cap_skid;
    end
  end

  // Request FSM
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_addr    <= RESET_PC;
      r_next_pc <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A redirect empties the skid buffer, so fetching can restart
          // directly at the target.
          if (Redirect) begin
            r_next_pc <= w_tgt;
            r_addr    <= w_tgt;
            r_state   <= S_REQ;
          end else if (!r_skid_vld || w_consume) begin
            r_addr  <= r_next_pc;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (Redirect) begin
            r_next_pc <= w_tgt;
            // Response already here: drop it and reissue at once. Otherwise
            // wait in DROP so the pending response can be swallowed.
            if (IMem_Ack) r_addr  <= w_tgt;
            else          r_state <= S_DROP;
          end else if (IMem_Ack) begin
            r_next_pc <= w_addr_p4;
            if (w_cap_skid) r_state <= S_IDLE;
            else            r_addr  <= w_addr_p4;
          end
        end
        S_DROP: begin
          if (Redirect) r_next_pc <= w_tgt;
          if (IMem_Ack) begin
            r_addr  <= Redirect ? w_tgt : r_next_pc;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef IF_PERF_COUNT_EN
  logic [31:0] r_fetch_cnt;
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)         r_fetch_cnt <= 32'd0;
    else if (w_capture) r_fetch_cnt <= r_fetch_cnt + 32'd1;
  end
  assign FetchCount = r_fetch_cnt;
`endif

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address loaded on reset.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  Clock  in  1  sole clock; all state updates on the rising edge
  Reset  in  1  asynchronous, active-low reset
  Stall  in  1  IF/ID hold request from the hazard unit (IF/ID WriteEnable = !Stall)
  Redirect  in  1  taken branch or jump; same cycle as the IF/ID Flush
  RedirectTarget  in  32  new fetch address, valid when Redirect=1
  IMem_Req  out  1  instruction-memory request
  IMem_Addr  out  32  request address, word aligned
  IMem_Ack  in  1  memory response; may assert in the same cycle as IMem_Req
  IMem_RData  in  32  instruction word, valid when IMem_Ack=1
  Instruction_Out  out  32  fetched instruction to IF/ID Instruction_In
  PC_Out  out  32  fetch address + 4 to IF/ID PC_In
  Valid_Out  out  1  output slot holds a live instruction
  FetchCount  out  32  present only with IF_PERF_COUNT_EN

Function
REQ-003 SHALL hold registers: state, IMem_Addr, NextPC, a 1-entry output slot (Instruction_Out, PC_Out, Valid_Out) and a 1-entry skid buffer (instr, pc+4, valid).
REQ-004 SHALL drive Instruction_Out = 0 and PC_Out = 0 whenever Valid_Out = 0, presenting a NOP bubble to IF/ID.
REQ-005 SHALL treat the slot as consumed at an edge where Valid_Out=1, Stall=0 and Redirect=0; on consumption the skid entry, if valid, moves into the slot, otherwise the slot empties.
REQ-006 SHALL implement states IDLE (IMem_Req=0), REQ (IMem_Req=1) and DROP (IMem_Req=1, response discarded); IMem_Addr SHALL stay constant while IMem_Req=1 and IMem_Ack=0.
REQ-007 IDLE: SHALL go to REQ with IMem_Addr<=NextPC when the skid buffer is empty after the edge; otherwise SHALL remain in IDLE.
REQ-008 REQ, Ack=1, Redirect=0: SHALL write {IMem_RData, IMem_Addr+4} to the slot if it is empty or consumed this edge, else to the skid buffer; NextPC <= IMem_Addr+4.
REQ-009 After REQ-008, SHALL stay in REQ with IMem_Addr<=IMem_Addr+4 if the skid buffer is empty, else go to IDLE; with Ack every cycle and Stall=0, throughput SHALL be 1 instruction per cycle.
REQ-010 REQ, Ack=0, Redirect=1: SHALL set NextPC<=RedirectTarget and go to DROP.
REQ-011 REQ, Ack=1, Redirect=1: SHALL discard IMem_RData and stay in REQ with IMem_Addr<=RedirectTarget and NextPC<=RedirectTarget.
REQ-012 DROP: SHALL discard the response when Ack=1, then go to REQ with IMem_Addr<=NextPC; a further Redirect in DROP SHALL only update NextPC.
REQ-013 Redirect=1 at any edge SHALL clear Valid_Out and the skid valid bit, overriding any capture or consumption on that edge.
REQ-014 Stall and Redirect together SHALL resolve as Redirect.
REQ-015 Address arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 SHALL wrap to 0.
REQ-016 No accepted instruction SHALL be lost or duplicated, and program order SHALL be preserved through the skid buffer.

Reset
REQ-017 Reset=0 SHALL immediately force state=IDLE, NextPC=IMem_Addr=RESET_PC, Valid_Out=0, skid valid=0, Instruction_Out=PC_Out=0, IMem_Req=0 and FetchCount=0.
REQ-018 Reset asserted mid-request SHALL abandon the request; the first request after release SHALL be to RESET_PC, issued at the first rising edge after Reset returns high (IMem_Req visible after that edge).

Configuration
REQ-019 Macro IF_PERF_COUNT_EN defined: the FetchCount port SHALL exist and SHALL increment by 1 per accepted, non-discarded Ack, wrapping modulo 2^32.
REQ-020 IF_PERF_COUNT_EN undefined: no FetchCount port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-021 Reset release, Ack tied 1, Stall=0 -> IMem_Addr 0,4,8,... one per cycle; Valid_Out=1 from the second edge; PC_Out = addr+4.
REQ-022 Stall=1 for 3 cycles with Ack=1 -> slot holds, the next word enters the skid buffer, IMem_Req=0; after release the words drain in order and none is lost.
REQ-023 Ack delayed 2 cycles and Redirect to 32'h0000_0100 mid-wait -> DROP, late data discarded, next IMem_Addr=32'h100.
REQ-024 Redirect on the same edge as Ack with slot and skid full -> both flushed, Valid_Out=0, Instruction_Out=0, next request to the target.
REQ-025 Reset pulsed low asynchronously mid-request -> outputs clear with no clock edge, then fetch restarts at RESET_PC; NextPC 32'hFFFF_FFFC fetches then wraps to 0.
REQ-026 With IF_PERF_COUNT_EN, 10 accepted plus 2 discarded Acks -> FetchCount=10.
